// File: rtl/epd_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : epd_timing_if
//  Description : Pixel-word handshake between memif (producer) and
//                epd_timing (consumer). One 64-bit word carries 32 pixels
//                at 2 bpp; ready is a one-cycle consume pulse.
//  Revision    : 1.0  initial release
// ============================================================================
interface epd_timing_if;
    logic [63:0] pix_read;
    logic        pix_read_valid;
    logic        pix_read_ready;

    modport master (
        output pix_read,
        output pix_read_valid,
        input  pix_read_ready
    );

    modport slave (
        input  pix_read,
        input  pix_read_valid,
        output pix_read_ready
    );
endinterface
`default_nettype wire

// File: rtl/epd_timing.sv
`default_nettype none
// ============================================================================
//  Module      : epd_timing
//  Description : Frame/line timing generator for EPD source and gate
//                drivers. Counts ticks (2 clk cycles each) across lines and
//                frames, decodes panel control strobes and serialises 64-bit
//                pixel words into four 16-bit source-data beats.
//  Revision    : 1.0  initial release
// ============================================================================
module epd_timing #(
    parameter int H_FP   = 2,
    parameter int H_SYNC = 2,
    parameter int H_BP   = 2,
    parameter int H_ACT  = 8,
    parameter int V_SYNC = 1,
    parameter int V_BP   = 1,
    parameter int V_ACT  = 2,
    parameter int V_FP   = 1
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          en,
    epd_timing_if.slave  pix,
    output logic         vsync,
    output logic         busy,
    output logic         underflow,
    output logic         epd_gdoe,
    output logic         epd_gdclk,
    output logic         epd_gdsp,
    output logic         epd_sdclk,
    output logic         epd_sdle,
    output logic         epd_sdoe,
    output logic         epd_sdce0,
    output logic [15:0]  epd_sd
);

    // Horizontal / vertical decode boundaries, in 12-bit counter units.
    localparam logic [11:0] c_H_LAST    = 12'(H_FP + H_SYNC + H_BP + H_ACT - 1);
    localparam logic [11:0] c_V_LAST    = 12'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [11:0] c_SDLE_ON   = 12'(H_FP);
    localparam logic [11:0] c_SDLE_OFF  = 12'(H_FP + H_SYNC);
    localparam logic [11:0] c_DATA_ON   = 12'(H_FP + H_SYNC + H_BP);
    localparam logic [11:0] c_GSP_OFF   = 12'(V_SYNC);
    localparam logic [11:0] c_ACT_V_ON  = 12'(V_SYNC + V_BP);
    localparam logic [11:0] c_ACT_V_OFF = 12'(V_SYNC + V_BP + V_ACT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_phase, w_phase_nxt;
    logic [11:0] r_h, w_h_nxt;
    logic [11:0] r_v, w_v_nxt;
    logic        w_frame_start;

    logic        r_vsync, r_busy, r_ready, r_underflow;
    logic        r_gdoe, r_gdclk, r_gdsp, r_sdclk, r_sdle, r_sdoe, r_sdce0;
    logic [15:0] r_sd;
    logic [63:0] r_word;

    logic        w_run_nxt, w_act_nxt, w_act_cur;
    logic [1:0]  w_k_nxt, w_k_cur;
    logic [63:0] w_new_word;
    logic [15:0] w_beat;

    // A tick is a data tick when it lies in an active line past the porches.
    function automatic logic f_active(input logic run, input logic [11:0] h,
                                      input logic [11:0] v);
        return run && (v >= c_ACT_V_ON) && (v < c_ACT_V_OFF) && (h >= c_DATA_ON);
    endfunction

    // Next-state and next-counter logic; a frame ends on the last cycle of the last tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_h_nxt       = r_h;
        w_v_nxt       = r_v;
        w_frame_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = 1'b0;
                w_h_nxt     = '0;
                w_v_nxt     = '0;
                if (en) begin
                    w_state_nxt   = ST_RUN;
                    w_frame_start = 1'b1;
                end
            end
            ST_RUN: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    if (r_h == c_H_LAST) begin
                        w_h_nxt = '0;
                        if (r_v == c_V_LAST) begin
                            w_v_nxt = '0;
                            if (en) begin
                                w_frame_start = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_v_nxt = r_v + 12'd1;
                        end
                    end else begin
                        w_h_nxt = r_h + 12'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run_nxt = (w_state_nxt == ST_RUN);
    assign w_act_nxt = f_active(w_run_nxt, w_h_nxt, w_v_nxt);
    assign w_k_nxt   = w_h_nxt[1:0] - c_DATA_ON[1:0];
    assign w_act_cur = f_active(r_state == ST_RUN, r_h, r_v);
    assign w_k_cur   = r_h[1:0] - c_DATA_ON[1:0];

    assign w_new_word = pix.pix_read_valid ? pix.pix_read : 64'h0;

    // Beat select for the word already held; beat 0 comes straight from the bus.
    always_comb begin
        w_beat = 16'h0;
        case (w_k_cur)
            2'd0: w_beat = r_word[15:0];
            2'd1: w_beat = r_word[31:16];
            2'd2: w_beat = r_word[47:32];
            2'd3: w_beat = r_word[63:48];
            default: w_beat = 16'h0;
        endcase
    end

    // State and tick counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_phase <= 1'b0;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    // Control strobes decoded from the upcoming tick so they line up with its first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_gdoe  <= 1'b0;
            r_gdclk <= 1'b0;
            r_gdsp  <= 1'b1;
            r_sdclk <= 1'b0;
            r_sdle  <= 1'b0;
            r_sdoe  <= 1'b0;
            r_sdce0 <= 1'b1;
        end else begin
            r_vsync <= w_frame_start;
            r_busy  <= w_run_nxt;
            r_ready <= w_act_nxt && !w_phase_nxt && (w_k_nxt == 2'd0);
            r_gdoe  <= w_run_nxt;
            r_gdclk <= w_run_nxt && (w_h_nxt >= c_SDLE_ON) && (w_h_nxt < c_DATA_ON);
            r_gdsp  <= !(w_run_nxt && (w_v_nxt < c_GSP_OFF));
            r_sdclk <= w_act_nxt && w_phase_nxt;
            r_sdle  <= w_run_nxt && (w_h_nxt >= c_SDLE_ON) && (w_h_nxt < c_SDLE_OFF);
            r_sdoe  <= w_run_nxt;
            r_sdce0 <= !w_act_nxt;
        end
    end

    // Word capture and beat shift at the end of each phase-0 cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_sd        <= '0;
            r_underflow <= 1'b0;
        end else if (!r_phase) begin
            if (w_act_cur) begin
                if (w_k_cur == 2'd0) begin
                    r_word <= w_new_word;
                    r_sd   <= w_new_word[15:0];
                    if (!pix.pix_read_valid) begin
                        r_underflow <= 1'b1;
                    end
                end else begin
                    r_sd <= w_beat;
                end
            end else begin
                r_sd <= '0;
            end
        end
    end

    assign pix.pix_read_ready = r_ready;
    assign vsync              = r_vsync;
    assign busy               = r_busy;
    assign underflow          = r_underflow;
    assign epd_gdoe           = r_gdoe;
    assign epd_gdclk          = r_gdclk;
    assign epd_gdsp           = r_gdsp;
    assign epd_sdclk          = r_sdclk;
    assign epd_sdle           = r_sdle;
    assign epd_sdoe           = r_sdoe;
    assign epd_sdce0          = r_sdce0;
    assign epd_sd             = r_sd;

endmodule
`default_nettype wire

// File: tb/tb_epd_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_epd_timing
//  Description : Self-checking bench for epd_timing. Expected outputs are
//                computed per frame cycle from tick/line arithmetic and a
//                per-frame table of random pixel words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_epd_timing;

    localparam int H_FP    = 2;
    localparam int H_SYNC  = 2;
    localparam int H_BP    = 2;
    localparam int H_ACT   = 8;
    localparam int V_SYNC  = 1;
    localparam int V_BP    = 1;
    localparam int V_ACT   = 2;
    localparam int V_FP    = 1;
    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACT;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int DS      = H_FP + H_SYNC + H_BP;
    localparam int FRAME   = 2 * H_TOTAL * V_TOTAL;
    localparam int WPL     = H_ACT / 4;
    localparam int WORDS   = V_ACT * WPL;

    // {vsync,busy,ready,gdoe,gdclk,gdsp,sdclk,sdle,sdoe,sdce0,sd}
    localparam logic [25:0] IDLE_VEC = {5'b00000, 1'b1, 3'b000, 1'b1, 16'h0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vsync, busy, underflow;
    logic        epd_gdoe, epd_gdclk, epd_gdsp, epd_sdclk, epd_sdle, epd_sdoe, epd_sdce0;
    logic [15:0] epd_sd;

    epd_timing_if pif();

    logic [63:0] mem [WORDS];
    logic        vld [WORDS];
    int          widx;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;
    logic        uf_exp;

    assign pif.pix_read       = (widx < WORDS) ? mem[widx] : 64'h0;
    assign pif.pix_read_valid = (widx < WORDS) ? vld[widx] : 1'b0;

    epd_timing dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pix       (pif),
        .vsync     (vsync),
        .busy      (busy),
        .underflow (underflow),
        .epd_gdoe  (epd_gdoe),
        .epd_gdclk (epd_gdclk),
        .epd_gdsp  (epd_gdsp),
        .epd_sdclk (epd_sdclk),
        .epd_sdle  (epd_sdle),
        .epd_sdoe  (epd_sdoe),
        .epd_sdce0 (epd_sdce0),
        .epd_sd    (epd_sd)
    );

    initial forever #5 clk = ~clk;

    wire [25:0] obs = {vsync, busy, pif.pix_read_ready, epd_gdoe, epd_gdclk, epd_gdsp,
                       epd_sdclk, epd_sdle, epd_sdoe, epd_sdce0, epd_sd};

    task automatic check(input string tag, input int t, input logic [63:0] o, input logic [63:0] e);
        n_total++;
        assert (o === e) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
        end
    endtask

    function automatic bit act_at(input int c);
        int tk, h, v;
        tk = c / 2;
        h  = tk % H_TOTAL;
        v  = tk / H_TOTAL;
        return (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACT) && (h >= DS);
    endfunction

    // Cycle (within a frame) at which word w is requested.
    function automatic int ready_cycle(input int w);
        return 2 * ((V_SYNC + V_BP + w / WPL) * H_TOTAL + DS + (w % WPL) * 4);
    endfunction

    function automatic logic [25:0] exp_vec(input int t);
        int tk, h, v, s, sh, sv, w, k;
        bit ph, act, rdy;
        logic [15:0] sd;
        logic [63:0] wv;
        tk  = t / 2;
        ph  = (t % 2) == 1;
        h   = tk % H_TOTAL;
        v   = tk / H_TOTAL;
        act = act_at(t);
        rdy = act && !ph && (((h - DS) % 4) == 0);
        // Source data shows a beat from the cycle after its phase-0 cycle, for two cycles.
        sd  = 16'h0;
        s   = ph ? t - 1 : t - 2;
        if (s >= 0 && act_at(s)) begin
            sh = (s / 2) % H_TOTAL;
            sv = (s / 2) / H_TOTAL;
            w  = (sv - (V_SYNC + V_BP)) * WPL + (sh - DS) / 4;
            k  = (sh - DS) % 4;
            wv = vld[w] ? mem[w] : 64'h0;
            sd = wv[16*k +: 16];
        end
        return {t == 0, 1'b1, rdy, 1'b1, (h >= H_FP) && (h < DS), !(v < V_SYNC),
                act && ph, (h >= H_FP) && (h < H_FP + H_SYNC), 1'b1, !act, sd};
    endfunction

    task automatic run_frame(input int drop_at, input int stop_at);
        bit pend;
        widx = 0;
        pend = 1'b0;
        for (int t = 0; t <= stop_at && t < FRAME; t++) begin
            if (t >= drop_at) en = 1'b0;
            @(posedge clk);
            #1;
            if (pend) widx++;
            pend = pif.pix_read_ready;
            check("frame", t, 64'(obs), 64'(exp_vec(t)));
            for (int w = 0; w < WORDS; w++) begin
                if (!vld[w] && t > ready_cycle(w)) uf_exp = 1'b1;
            end
            check("underflow", t, 64'(underflow), 64'(uf_exp));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle", i, 64'(obs), 64'(IDLE_VEC));
            check("idle_underflow", i, 64'(underflow), 64'(uf_exp));
        end
    endtask

    task automatic load_random(input int bad);
        for (int w = 0; w < WORDS; w++) begin
            mem[w] = {$urandom, $urandom};
            vld[w] = (w != bad);
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        widx   = WORDS;
        uf_exp = 1'b0;
        for (int w = 0; w < WORDS; w++) begin
            mem[w] = 64'h0;
            vld[w] = 1'b1;
        end

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, 64'(obs), 64'(IDLE_VEC));
        check("reset_underflow", 0, 64'(underflow), 64'h0);
        rst = 1'b0;
        idle_cycles(2);

        // Frame with the fixed word pattern.
        mem[0] = 64'h1111_1111_1111_1111;
        mem[1] = 64'h2222_2222_2222_2222;
        mem[2] = 64'h3333_3333_3333_3333;
        mem[3] = 64'h4444_4444_4444_4444;
        en = 1'b1;
        run_frame(FRAME, FRAME - 1);

        // Back-to-back frame with random words.
        load_random(-1);
        run_frame(FRAME, FRAME - 1);

        // Third word arrives with valid low.
        load_random(2);
        run_frame(FRAME, FRAME - 1);

        // en drops at cycle 50: frame completes, then stays idle.
        load_random(-1);
        run_frame(50, FRAME - 1);
        idle_cycles(20);

        // Restart, then reset in the middle of an active beat with en still high.
        en = 1'b1;
        load_random(-1);
        run_frame(FRAME, 70);
        rst = 1'b1;
        @(posedge clk);
        #1;
        uf_exp = 1'b0;
        check("midreset", 0, 64'(obs), 64'(IDLE_VEC));
        check("midreset_underflow", 0, 64'(underflow), 64'(uf_exp));
        rst = 1'b0;

        // Fresh frame after reset, ending with en low on the last cycle.
        load_random(-1);
        run_frame(FRAME - 1, FRAME - 1);
        idle_cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
